// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the RV32M divide sequencer: ALU control codes,
// {funct7,funct3} decode values, FSM state type and op-class helpers.
package div_sequencer_pkg;

  localparam logic [4:0] OPADD  = 5'd0;
  localparam logic [4:0] OPDIV  = 5'd16;
  localparam logic [4:0] OPDIVU = 5'd17;
  localparam logic [4:0] OPREM  = 5'd18;
  localparam logic [4:0] OPREMU = 5'd19;

  localparam logic [9:0] FUNADD  = {7'b0000000, 3'b000};
  localparam logic [9:0] FUNDIV  = {7'b0000001, 3'b100};
  localparam logic [9:0] FUNDIVU = {7'b0000001, 3'b101};
  localparam logic [9:0] FUNREM  = {7'b0000001, 3'b110};
  localparam logic [9:0] FUNREMU = {7'b0000001, 3'b111};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OPDIV) || (op == OPDIVU) || (op == OPREM) || (op == OPREMU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == OPDIV) || (op == OPREM);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == OPREM) || (op == OPREMU);
  endfunction

  // R-type decode helper; anything that is not an M-extension divide maps to OPADD.
  function automatic logic [4:0] op_from_funct(input logic [9:0] funct);
    logic [4:0] op;
    case (funct)
      FUNDIV:  op = OPDIV;
      FUNDIVU: op = OPDIVU;
      FUNREM:  op = OPREM;
      FUNREMU: op = OPREMU;
      FUNADD:  op = OPADD;
      default: op = OPADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between the EX stage and the divide sequencer.
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             iStart;
  logic [4:0]       iOp;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iFlush;
  logic             oBusy;
  logic             oValid;
  logic [WIDTH-1:0] oResult;

  modport master (
    output iStart, iOp, iA, iB, iFlush,
    input  oBusy, oValid, oResult
  );

  modport slave (
    input  iStart, iOp, iA, iB, iFlush,
    output oBusy, oValid, oResult
  );
endinterface

// File: rtl/div_sequencer_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left and
// keep the trial difference when it does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // The partial remainder stays below the divisor, so the top bit of diff is a clean borrow.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {2'b00, divisor_i};
    if (diff[WIDTH+1]) begin
      rem_o = shifted[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = diff[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: magnitude restoring division,
// one bit per cycle, sign fix-up, then a single-cycle oValid pulse.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           iCLK,
  input  logic           iRST_n,
  div_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic             is_signed_q, is_signed_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             rem_sel_q, rem_sel_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  logic             op_signed, op_rem, accept, b_zero, ovf;
  logic [WIDTH-1:0] min_neg, a_mag, b_mag, q_fix, r_fix;

  always_comb begin
    op_signed = is_signed_op(bus.iOp);
    op_rem    = is_rem_op(bus.iOp);
    min_neg   = '0;
    min_neg[WIDTH-1] = 1'b1;
    b_zero    = (bus.iB == '0);
    ovf       = op_signed && (bus.iA == min_neg) && (&bus.iB);
    // -2^(WIDTH-1) negates to itself, which is already the correct unsigned magnitude.
    a_mag     = (op_signed && bus.iA[WIDTH-1]) ? -bus.iA : bus.iA;
    b_mag     = (op_signed && bus.iB[WIDTH-1]) ? -bus.iB : bus.iB;
    // busy_q still high means the result pulse is on the bus; a held request must not restart.
    accept    = bus.iStart && !bus.iFlush && (state_q == ST_IDLE) && !busy_q
                && is_div_op(bus.iOp);
    q_fix     = (is_signed_q && (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
    r_fix     = (is_signed_q && sign_a_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    is_signed_d = is_signed_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    rem_sel_d   = rem_sel_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    busy_d      = (state_q != ST_IDLE);
    valid_d     = (state_q == ST_DONE);

    if (bus.iFlush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            is_signed_d = op_signed;
            sign_a_d    = bus.iA[WIDTH-1];
            sign_b_d    = bus.iB[WIDTH-1];
            rem_sel_d   = op_rem;
            quo_d       = a_mag;
            div_d       = b_mag;
            rem_d       = '0;
            cnt_d       = '0;
            if (b_zero) begin
              result_d = op_rem ? bus.iA : '1;
              state_d  = ST_DONE;
            end else if (ovf) begin
              result_d = op_rem ? '0 : min_neg;
              state_d  = ST_DONE;
            end else begin
              state_d  = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          result_d = rem_sel_q ? r_fix : q_fix;
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_q     <= ST_IDLE;
      is_signed_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      rem_sel_q   <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_signed_q <= is_signed_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      rem_sel_q   <= rem_sel_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.oBusy   = busy_q;
  assign bus.oValid  = valid_q;
  assign bus.oResult = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Randomised scoreboard bench for div_sequencer: expected result and arrival
// cycle are queued at issue and checked by an independent monitor.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [31:0] last_res = 32'h0;

  div_sequencer_if #(.WIDTH(32)) bus ();

  div_sequencer #(.WIDTH(32)) dut (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (((op == OPDIV) || (op == OPREM)) && (a == MIN_NEG) && (b == 32'hFFFF_FFFF));
  endfunction

  // Reference: RISC-V M-extension semantics expressed with native arithmetic.
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'h0) return ((op == OPREM) || (op == OPREMU)) ? a : 32'hFFFF_FFFF;
    if (op == OPDIVU) return a / b;
    if (op == OPREMU) return a % b;
    if ((a == MIN_NEG) && (b == 32'hFFFF_FFFF)) return (op == OPREM) ? 32'h0 : MIN_NEG;
    if (op == OPDIV) return sa / sb;
    return sa % sb;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every oValid pulse must match the head of the scoreboard in value and cycle.
  always @(negedge clk) begin
    if (bus.oValid === 1'b1) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got oValid=1 result=0x%08h expected no pulse (cycle %0d)",
                 bus.oResult, cyc);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (bus.oResult !== e.res) begin
          failures++;
          $display("FAIL result: got 0x%08h expected 0x%08h (cycle %0d)", bus.oResult, e.res, cyc);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL latency: got valid at cycle %0d expected cycle %0d", cyc, e.cyc);
        end
        $display("txn result=0x%08h at cycle %0d", bus.oResult, cyc);
      end
    end
  end

  // Issue one op, hold the request until oValid, check oBusy every cycle.
  // glitch: drop and re-raise iStart with different operands during RUN.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit glitch);
    int   n0, lat, n;
    exp_t e;
    logic exp_busy;
    @(negedge clk);
    bus.iStart = 1'b1;
    bus.iOp    = op;
    bus.iA     = a;
    bus.iB     = b;
    n0  = cyc + 1;
    lat = is_special(op, a, b) ? 1 : 34;
    e.res = ref_result(op, a, b);
    e.cyc = n0 + lat;
    exp_q.push_back(e);
    last_res = e.res;
    $display("issue op=%0d a=0x%08h b=0x%08h expect=0x%08h", op, a, b, e.res);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      exp_busy = (cyc >= n0 + 1) && (cyc <= n0 + lat);
      check("busy", {31'b0, bus.oBusy}, {31'b0, exp_busy});
      if (glitch && (lat > 1)) begin
        if (cyc == n0 + 2) bus.iStart = 1'b0;
        if (cyc == n0 + 5) begin
          bus.iStart = 1'b1;
          bus.iOp    = OPDIV;
          bus.iA     = 32'd5;
          bus.iB     = 32'd0;
        end
      end
    end while ((bus.oValid !== 1'b1) && (n < 100));
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL timeout: got no oValid expected one within 100 cycles (cycle %0d)", cyc);
    end
    bus.iStart = 1'b0;
  endtask

  initial begin
    logic [4:0] ops[4];
    ops[0] = OPDIV; ops[1] = OPDIVU; ops[2] = OPREM; ops[3] = OPREMU;
    bus.iStart = 1'b0;
    bus.iOp    = OPADD;
    bus.iA     = 32'h0;
    bus.iB     = 32'h0;
    bus.iFlush = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, bus.oBusy}, 32'h0);
    check("reset_valid", {31'b0, bus.oValid}, 32'h0);
    check("reset_result", bus.oResult, 32'h0);
    rst_n = 1'b1;

    do_op(OPDIVU, 32'd100, 32'd7, 1'b0);
    do_op(OPREMU, 32'd100, 32'd7, 1'b0);
    do_op(OPDIV, -32'sd7, 32'd2, 1'b0);
    do_op(OPREM, -32'sd7, 32'd2, 1'b0);
    do_op(OPREM, 32'd7, -32'sd2, 1'b0);
    do_op(OPDIV, 32'd5, 32'd0, 1'b0);
    do_op(OPREMU, 32'd5, 32'd0, 1'b0);
    do_op(OPDIV, MIN_NEG, 32'hFFFF_FFFF, 1'b0);
    do_op(OPREM, MIN_NEG, 32'hFFFF_FFFF, 1'b0);
    do_op(OPDIVU, 32'd1000, 32'd9, 1'b1);

    // Flush at cycle 10 of a running op: IDLE next edge, no pulse, result held.
    @(negedge clk);
    bus.iStart = 1'b1; bus.iOp = OPDIVU; bus.iA = 32'd1000; bus.iB = 32'd7;
    repeat (11) @(negedge clk);
    bus.iFlush = 1'b1; bus.iStart = 1'b0;
    @(negedge clk);
    bus.iFlush = 1'b0;
    check("flush_busy", {31'b0, bus.oBusy}, 32'h0);
    check("flush_result", bus.oResult, last_res);
    repeat (40) @(negedge clk);
    check("flush_idle_busy", {31'b0, bus.oBusy}, 32'h0);

    // Reset at cycle 10 of a running op: everything returns to zero.
    bus.iStart = 1'b1; bus.iOp = OPDIV; bus.iA = 32'd77; bus.iB = 32'd5;
    repeat (11) @(negedge clk);
    rst_n = 1'b0; bus.iStart = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'b0, bus.oBusy}, 32'h0);
    check("rst_valid", {31'b0, bus.oValid}, 32'h0);
    check("rst_result", bus.oResult, 32'h0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    do_op(OPDIVU, 32'd9, 32'd3, 1'b0);

    // Non-divide op and flush-with-start in IDLE must both be ignored.
    bus.iStart = 1'b1; bus.iOp = OPADD; bus.iA = 32'd3; bus.iB = 32'd4;
    repeat (3) begin
      @(negedge clk);
      check("opadd_busy", {31'b0, bus.oBusy}, 32'h0);
    end
    bus.iOp = OPDIVU; bus.iFlush = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0; bus.iFlush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", {31'b0, bus.oBusy}, 32'h0);

    for (int i = 0; i < 40; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      int          r;
      op = ops[$urandom_range(0, 3)];
      a  = $urandom;
      if ($urandom_range(0, 7) == 0) a = MIN_NEG;
      r = $urandom_range(0, 9);
      if (r == 0)      b = 32'h0;
      else if (r == 1) b = 32'hFFFF_FFFF;
      else if (r == 2) b = 32'($urandom_range(1, 15));
      else             b = $urandom >> $urandom_range(0, 31);
      do_op(op, a, b, ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
